imem_loader: RTL and testbench

//  Writer side of the instruction-memory interface: accepts a framed byte stream (from a UART receiver or

---
 rtl/imem_loader.sv | 175 +++++++++++++++++
 tb/tb_imem_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length-prefixed byte stream, packs big-endian words,
// writes them to sequential addresses and releases cpu_hold once the frame checksum matches.
module imem_loader #(
  parameter int ADDR_W        = 8,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [7:0]        byte_in_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o
);

  // state    | meaning
  // S_IDLE   | waiting for start, nothing loaded yet
  // S_LEN_HI | expecting high byte of word count
  // S_LEN_LO | expecting low byte of word count, range-checked on capture
  // S_DATA   | packing data bytes, one write per 4 bytes
  // S_CHECK  | expecting checksum byte
  // S_DONE   | frame loaded, processor released
  // S_ERROR  | length or checksum failure, processor held
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [23:0]         word_q, word_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]          acc_q, acc_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                xfer;
  logic [15:0]         len_full;
  logic [16:0]         next_cnt;

  assign byte_ready_o = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
  assign xfer         = byte_valid_i && byte_ready_o;
  assign len_full     = {len_q[15:8], byte_in_i};
  assign next_cnt     = 17'(word_count_q) + 17'd1;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    acc_d        = acc_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    word_count_d = word_count_q;
    cpu_hold_d   = cpu_hold_q;
    done_d       = done_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d      = S_LEN_HI;
          cpu_hold_d   = 1'b1;
          done_d       = 1'b0;
          err_d        = 1'b0;
          word_count_d = '0;
          acc_d        = '0;
          byte_cnt_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_in_i;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = byte_in_i;
          if (len_full == 16'd0) begin
            state_d = S_CHECK;
          end else if ({1'b0, len_full} > DEPTH) begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            cpu_hold_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d     = {word_q[15:0], byte_in_i};
          acc_d      = acc_q ^ byte_in_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // word_count_q is settled here: the previous write completed at least 3 cycles ago
          if (byte_cnt_q == 2'd3) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = word_count_q[ADDR_W-1:0];
            wr_data_d    = {word_q, byte_in_i};
            word_count_d = word_count_q + (ADDR_W+1)'(1);
            if (next_cnt == {1'b0, len_q}) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (byte_in_i == acc_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            cpu_hold_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      acc_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      word_count_q <= '0;
      cpu_hold_q   <= HOLD_AT_RESET;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      acc_q        <= acc_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      word_count_q <= word_count_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign word_count_o = word_count_q;
  assign cpu_hold_o   = cpu_hold_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random frames with gaps and stray starts, checked against expected
// write lists and completion flags derived from the frame contents.
module tb_imem_loader;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready, wr_en, cpu_hold, done, err;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   word_count;
  logic          h0_byte_ready, h0_wr_en, h0_cpu_hold, h0_done, h0_err;
  logic [AW-1:0] h0_wr_addr;
  logic [31:0]   h0_wr_data;
  logic [AW:0]   h0_word_count;

  imem_loader #(.ADDR_W(AW), .HOLD_AT_RESET(1'b1)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .byte_in_i(byte_in),
    .byte_valid_i(byte_valid), .byte_ready_o(byte_ready), .wr_en_o(wr_en),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .word_count_o(word_count),
    .cpu_hold_o(cpu_hold), .done_o(done), .err_o(err)
  );

  imem_loader #(.ADDR_W(AW), .HOLD_AT_RESET(1'b0)) u_dut_h0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .byte_in_i(byte_in),
    .byte_valid_i(byte_valid), .byte_ready_o(h0_byte_ready), .wr_en_o(h0_wr_en),
    .wr_addr_o(h0_wr_addr), .wr_data_o(h0_wr_data), .word_count_o(h0_word_count),
    .cpu_hold_o(h0_cpu_hold), .done_o(h0_done), .err_o(h0_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] qa[$];
  logic [31:0]   qd[$];
  logic [31:0]   fw [DEPTH];

  always @(negedge clk) if (wr_en) begin
    qa.push_back(wr_addr);
    qd.push_back(wr_data);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap, input bit noisy);
    int gap;
    int k;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (gap) begin
      byte_valid = 1'b0;
      start      = noisy && ($urandom_range(2, 0) == 0);
      @(negedge clk);
    end
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_in    = b;
    k = 0;
    while (!byte_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!byte_ready) check_eq("ready_timeout", 64'(byte_ready), 64'(1));
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic start_frame();
    qa.delete();
    qd.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_done", 64'(done), 64'(0));
    check_eq("start_err", 64'(err), 64'(0));
    check_eq("start_hold", 64'(cpu_hold), 64'(1));
    check_eq("start_hold0", 64'(h0_cpu_hold), 64'(1));
    check_eq("start_ready", 64'(byte_ready), 64'(1));
  endtask

  // chk_sel: -1 correct checksum, -2 random wrong checksum, else literal checksum byte
  task automatic run_frame(input int n, input int chk_sel, input int maxgap,
                           input bit noisy, input bit keep_words);
    logic [7:0] x;
    logic [7:0] chk;
    int         exp_w;
    bit         ok;
    int         k;
    start_frame();
    send_byte(8'(n >> 8), maxgap, noisy);
    send_byte(8'(n), maxgap, noisy);
    x = 8'h00;
    chk = 8'h00;
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        if (!keep_words) fw[i] = $urandom;
        for (int b = 3; b >= 0; b--) begin
          x ^= fw[i][8*b +: 8];
          send_byte(fw[i][8*b +: 8], maxgap, noisy);
        end
      end
      if (chk_sel == -1)      chk = x;
      else if (chk_sel == -2) chk = x ^ 8'($urandom_range(255, 1));
      else                    chk = 8'(chk_sel);
      send_byte(chk, maxgap, noisy);
    end
    k = 0;
    while (!(done || err) && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    ok    = (n <= DEPTH) && (chk == x);
    exp_w = (n <= DEPTH) ? n : 0;
    check_eq("done", 64'(done), 64'(ok));
    check_eq("err", 64'(err), 64'(!ok));
    check_eq("cpu_hold", 64'(cpu_hold), 64'(!ok));
    check_eq("cpu_hold_h0", 64'(h0_cpu_hold), 64'(!ok));
    check_eq("ready_end", 64'(byte_ready), 64'(0));
    check_eq("word_count", 64'(word_count), 64'(exp_w));
    check_eq("num_writes", 64'(qa.size()), 64'(exp_w));
    for (int i = 0; i < exp_w && i < qa.size(); i++) begin
      check_eq("wr_addr", 64'(qa[i]), 64'(i));
      check_eq("wr_data", 64'(qd[i]), 64'(fw[i]));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_wr_en"}, 64'(wr_en), 64'(0));
    check_eq({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
    check_eq({tag, "_wr_data"}, 64'(wr_data), 64'(0));
    check_eq({tag, "_word_count"}, 64'(word_count), 64'(0));
    check_eq({tag, "_done"}, 64'(done), 64'(0));
    check_eq({tag, "_err"}, 64'(err), 64'(0));
    check_eq({tag, "_ready"}, 64'(byte_ready), 64'(0));
    check_eq({tag, "_hold"}, 64'(cpu_hold), 64'(1));
    check_eq({tag, "_hold0"}, 64'(h0_cpu_hold), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    fw[0] = 32'hDEADBEEF;
    fw[1] = 32'h01020304;
    run_frame(2, -1, 0, 1'b0, 1'b1);
    run_frame(2, 0, 0, 1'b0, 1'b1);
    run_frame(257, -1, 0, 1'b0, 1'b0);
    run_frame(0, 0, 0, 1'b0, 1'b0);
    run_frame(2, -1, 5, 1'b1, 1'b1);
    run_frame(DEPTH, -1, 0, 1'b0, 1'b0);

    for (int f = 0; f < 10; f++) begin
      int n;
      n = ($urandom_range(9, 0) == 0) ? int'($urandom_range(65535, DEPTH + 1))
                                      : int'($urandom_range(8, 1));
      run_frame(n, ($urandom_range(2, 0) == 0) ? -2 : -1, 5, 1'b1, 1'b0);
    end

    fw[0] = 32'hDEADBEEF;
    fw[1] = 32'h01020304;
    start_frame();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    for (int b = 3; b >= 0; b--) send_byte(fw[0][8*b +: 8], 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(2, -1, 2, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
